// File: rtl/prewish_button_poller.sv
// Periodic poller for the button debouncer: requests a status byte every
// POLL_CYCLES, captures the reply and publishes held state, edge pulses and a sticky timeout.
module prewish_button_poller #(
  parameter int POLL_CYCLES    = 48000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_enable,
  output logic       STB_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_status,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_event,
  output logic       o_timeout,
  output logic       o_alive,
  output logic [1:0] dbg_state
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] pcnt, pcnt_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          capture;
  logic          expire;

  // Handshake: STB_O is a one-cycle request; the reply is accepted only in
  // WAIT, in any cycle where STB_I is high, and DAT_I is sampled in that cycle.
  always_comb begin
    state_next = state;
    pcnt_next  = pcnt;
    tcnt_next  = tcnt;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          if (pcnt == '0) begin
            state_next = REQ;
            tcnt_next  = TW'(TIMEOUT_CYCLES);
          end else begin
            pcnt_next = pcnt - 1'b1;
          end
        end
      end
      REQ: begin
        state_next = WAIT;
        tcnt_next  = tcnt - 1'b1;
      end
      WAIT: begin
        // A reply in the final WAIT cycle beats the timeout.
        if (STB_I) begin
          capture    = 1'b1;
          state_next = IDLE;
          pcnt_next  = PW'(POLL_CYCLES - 1);
        end else if (tcnt == '0) begin
          expire     = 1'b1;
          state_next = IDLE;
          pcnt_next  = PW'(POLL_CYCLES - 1);
        end else begin
          tcnt_next = tcnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        pcnt_next  = PW'(POLL_CYCLES - 1);
      end
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      pcnt  <= PW'(POLL_CYCLES - 1);
      tcnt  <= '0;
    end else begin
      state <= state_next;
      pcnt  <= pcnt_next;
      tcnt  <= tcnt_next;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      STB_O      <= 1'b0;
      o_status   <= 8'h00;
      o_pressed  <= 8'h00;
      o_released <= 8'h00;
      o_event    <= 1'b0;
      o_timeout  <= 1'b0;
      o_alive    <= 1'b0;
    end else begin
      STB_O      <= (state_next == REQ);
      o_pressed  <= 8'h00;
      o_released <= 8'h00;
      o_event    <= 1'b0;
      if (capture) begin
        o_status   <= DAT_I;
        o_pressed  <= DAT_I & ~o_status;
        o_released <= ~DAT_I & o_status;
        o_event    <= |(DAT_I ^ o_status);
        o_alive    <= ~o_alive;
      end
      if (expire) begin
        o_timeout <= 1'b1;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_prewish_button_poller.sv
// Bench for prewish_button_poller: a debouncer stub answers polls from a
// scripted table; a monitor checks every capture against the expected queue.
module tb_prewish_button_poller;

  localparam int POLL = 8;
  localparam int TMO  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       stb_i = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic       stb_o;
  logic [7:0] status, pressed, released;
  logic       ev, timeout, alive;
  logic [1:0] dbg_state;

  prewish_button_poller #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_I(clk), .RST_I(rst), .i_enable(enable), .STB_O(stb_o),
    .STB_I(stb_i), .DAT_I(dat_i), .o_status(status), .o_pressed(pressed),
    .o_released(released), .o_event(ev), .o_timeout(timeout),
    .o_alive(alive), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Expected capture record: {status, pressed, released, event}.
  logic [24:0] exp_q[$];
  // Stub script entry: {reply byte, expected capture record}.
  logic [32:0] stub_q[$];
  int          stub_delay = 2;
  int          stub_skip = 0;
  int          stub_cnt = -1;
  logic [7:0]  stub_d;
  logic [24:0] stub_e;
  logic        manual_pulse = 1'b0;
  logic [7:0]  manual_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, req);
    end
  endtask

  // clock/reset bookkeeping
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Debouncer stub: replies stub_delay cycles after seeing STB_O.
  initial forever begin
    @(negedge clk);
    stb_i = 1'b0;
    dat_i = 8'h00;
    if (manual_pulse) begin
      stb_i = 1'b1;
      dat_i = manual_data;
      manual_pulse = 1'b0;
    end else if (rst) begin
      stub_cnt = -1;
    end else begin
      if (stub_cnt == 0) begin
        stb_i = 1'b1;
        dat_i = stub_d;
        exp_q.push_back(stub_e);
        stub_cnt = -1;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
      end
      if (stb_o) begin
        if (stub_skip > 0) begin
          stub_skip--;
        end else if (stub_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unscripted_poll: STB_O at cycle %0d, no reply scripted", cyc);
        end else begin
          {stub_d, stub_e} = stub_q.pop_front();
          stub_cnt = stub_delay - 1;
        end
      end
    end
  end

  // Monitor: a capture is signalled by o_alive toggling.
  initial begin : monitor
    logic [24:0] e;
    logic        prev_alive;
    prev_alive = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_alive = 1'b0;
      end else if (alive !== prev_alive) begin
        prev_alive = alive;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_capture: status 'h%0h, nothing expected", status);
        end else begin
          e = exp_q.pop_front();
          check("cap_status", 32'(status), 32'(e[24:17]));
          check("cap_pressed", 32'(pressed), 32'(e[16:9]));
          check("cap_released", 32'(released), 32'(e[8:1]));
          check("cap_event", 32'(ev), 32'(e[0]));
        end
      end else begin
        check("pulse_clear", 32'({pressed, released, ev}), 32'd0);
      end
    end
  end

  task automatic wait_stb(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stb_o) begin
        at = cyc;
        break;
      end
    end
    vectors++;
    if (at < 0) begin
      miscompares++;
      $display("FAIL stb_wait: no STB_O within %0d cycles, want a pulse", budget);
    end
  endtask

  task automatic drain(input int n);
    int left;
    left = 20;
    repeat (n) @(negedge clk);
    while (exp_q.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rel, s1, s2, s3, r, s;
    bit seen;

    // Hand-computed script: reply byte, then {status, pressed, released, event}.
    stub_q.push_back({8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
    stub_q.push_back({8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
    stub_q.push_back({8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
    stub_q.push_back({8'h01, 8'h01, 8'h01, 8'h00, 1'b1});
    stub_q.push_back({8'h05, 8'h05, 8'h04, 8'h00, 1'b1});
    stub_q.push_back({8'h04, 8'h04, 8'h00, 8'h01, 1'b1});
    stub_q.push_back({8'h80, 8'h80, 8'h80, 8'h04, 1'b1});
    stub_q.push_back({8'h10, 8'h10, 8'h10, 8'h00, 1'b1});
    stub_q.push_back({8'h22, 8'h22, 8'h22, 8'h10, 1'b1});
    stub_q.push_back({8'h20, 8'h20, 8'h00, 8'h02, 1'b1});

    // Reset values and first poll
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_status", 32'(status), 32'h00);
    check("rst_pulses", 32'({pressed, released, ev}), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_alive", 32'(alive), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    rel = cyc;
    wait_stb(20, s1);
    check("first_stb", 32'(s1 - rel), 32'd8);
    @(negedge clk);
    check("stb_width", 32'(stb_o), 32'd0);
    wait_stb(20, s2);
    check("period_1", 32'(s2 - s1), 32'd11);
    wait_stb(20, s3);
    check("period_2", 32'(s3 - s2), 32'd11);
    drain(4);
    check("alive_after_3", 32'(alive), 32'd1);

    // Press and release
    wait_stb(20, s);
    drain(4);
    check("t2_status_a", 32'(status), 32'h01);
    wait_stb(20, s);
    drain(4);
    check("t2_status_b", 32'(status), 32'h05);
    wait_stb(20, s);
    drain(4);
    check("t2_status_c", 32'(status), 32'h04);

    // Timeout: one silent poll
    stub_skip = 1;
    wait_stb(20, r);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("timeout_early", 32'(timeout), 32'd0);
      if (k == 7) check("timeout_set", 32'(timeout), 32'd1);
    end
    check("timeout_status", 32'(status), 32'h04);
    wait_stb(20, s);
    drain(4);
    check("timeout_sticky", 32'(timeout), 32'd1);
    check("after_timeout_status", 32'(status), 32'h80);

    // Collision: reply lands in the last WAIT cycle
    @(negedge clk);
    rst = 1'b1;
    stub_delay = TMO;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_stb(20, s);
    repeat (7) @(negedge clk);
    check("coll_status", 32'(status), 32'h10);
    check("coll_pressed", 32'(pressed), 32'h10);
    check("coll_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    check("coll_timeout_hold", 32'(timeout), 32'd0);
    drain(1);
    stub_delay = 2;

    // Enable gating mid-IDLE
    wait_stb(20, s);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_o) seen = 1'b1;
    end
    check("idle_gate_quiet", 32'(seen), 32'd0);
    enable = 1'b1;
    wait_stb(20, s2);
    check("idle_gate_resume", 32'(s2 - s), 32'd31);

    // Enable gating during WAIT; the in-flight reply still lands
    @(negedge clk);
    enable = 1'b0;
    stub_skip = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_o) seen = 1'b1;
    end
    check("wait_gate_quiet", 32'(seen), 32'd0);
    check("wait_gate_capture", 32'(exp_q.size()), 32'd0);
    check("wait_gate_status", 32'(status), 32'h20);
    enable = 1'b1;
    wait_stb(20, s3);
    check("wait_gate_resume", 32'(s3 - s2), 32'd29);

    // Async reset mid-WAIT, then a late reply
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("areset_stb", 32'(stb_o), 32'd0);
    check("areset_status", 32'(status), 32'h00);
    check("areset_pulses", 32'({pressed, released, ev}), 32'd0);
    check("areset_timeout", 32'(timeout), 32'd0);
    check("areset_alive", 32'(alive), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    manual_data = 8'hFF;
    manual_pulse = 1'b1;
    repeat (4) @(negedge clk);
    check("late_status", 32'(status), 32'h00);
    check("late_alive", 32'(alive), 32'd0);
    check("late_state", 32'(dbg_state), 32'd0);

    check("script_used", 32'(stub_q.size()), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prewish_button_poller.md
# prewish_button_poller

Periodic poller mentor that sits directly downstream of the button debouncer. It raises a one-cycle request strobe toward the debouncer at a fixed interval and captures the status byte that comes back on the reply strobe. It then publishes the held button state, one-cycle press/release event pulses, and a sticky timeout flag to the blinky/mask logic. All logic runs in the fast system clock domain.

## Interface
- POLL_CYCLES, 48000, CLK_I cycles spent in IDLE between polls; must be ≥ 2
- TIMEOUT_CYCLES, 255, maximum CLK_I cycles spent in WAIT for a reply; must be ≥ 1
- CLK_I  in  1  system clock; all state changes on the rising edge
- RST_I  in  1  reset, asynchronous, active-high
- i_enable  in  1  when high, the poll interval counter runs; when low, no new requests are issued
- STB_O  out  1  poll request to the debouncer; one-cycle pulse
- STB_I  in  1  reply strobe from the debouncer; DAT_I is valid only in cycles where it is high
- DAT_I  in  8  debouncer status byte, active-high per button
- o_status  out  8  last captured status byte
- o_pressed  out  8  one-cycle pulse per bit that went 0→1 between consecutive captures
- o_released  out  8  one-cycle pulse per bit that went 1→0 between consecutive captures
- o_event  out  1  one-cycle pulse; high exactly when any bit of o_pressed or o_released is high
- o_timeout  out  1  sticky; set when a poll receives no reply, cleared only by RST_I
- o_alive  out  1  toggles on every successful capture

## Operation
- **States**
  - IDLE: counts the poll interval.
  - REQ: drives the request.
  - WAIT: waits for the reply.
  - Encoding is free.
- **IDLE**
  - The poll counter pcnt (width $clog2(POLL_CYCLES)) is loaded with POLL_CYCLES-1 on entry and on reset.
  - When i_enable=1, pcnt decrements each cycle. When i_enable=0, pcnt holds.
  - When pcnt==0 and i_enable=1, go to REQ.
- **REQ**
  - STB_O=1 for exactly this one cycle.
  - The timeout counter tcnt (width $clog2(TIMEOUT_CYCLES+1)) is loaded with TIMEOUT_CYCLES.
  - Unconditionally go to WAIT.
- **WAIT, reply arrives (STB_I=1)**
  - On that edge: o_status←DAT_I, o_pressed←DAT_I & ~o_status, o_released←~DAT_I & o_status, o_event←|(pressed|released), o_alive←~o_alive.
  - Go to IDLE.
- **WAIT, no reply (STB_I=0)**
  - tcnt decrements each cycle.
  - When tcnt reaches 0 with STB_I still low, set o_timeout and go to IDLE. o_status is unchanged and no event pulses are generated.
- **Reply vs. timeout collision:** if STB_I is high in the same cycle that tcnt==0, the reply wins and is captured normally. o_timeout is not set.
- **Event pulse clearing:** o_pressed, o_released and o_event are forced to 0 in every cycle other than the one immediately after a capture.
- **Stray STB_I** (in IDLE or REQ) is ignored and has no side effects.
- **i_enable deasserted mid-transaction** (REQ/WAIT): the transaction completes normally. Only the next IDLE countdown freezes.
- **First capture after reset** compares against o_status=0. Any bit already high therefore produces a pressed pulse.
- **Reset mid-transaction:** all state returns to reset values immediately. A late STB_I arriving afterwards is ignored because the block is in IDLE.

## Timing
- **Reset values:** STB_O=0, o_status=8'h00, o_pressed=8'h00, o_released=8'h00, o_event=0, o_timeout=0, o_alive=0, state=IDLE, pcnt=POLL_CYCLES-1.
- **Interval:** with i_enable held high from reset release, the first STB_O pulse occurs POLL_CYCLES cycles after the first active edge.
- **Poll period:** POLL_CYCLES + 1 + W cycles, where W is the number of WAIT cycles including the capture cycle.
- **Reply handshake:** the debouncer raises STB_I after seeing STB_O high and then low. A two-cycle-delayed reply gives W=2.
- **Capture latency:** o_status, event pulses and the o_alive toggle are visible in the cycle after STB_I is sampled high. Event pulses last exactly one cycle.
- **Timeout:** with no reply, IDLE is re-entered TIMEOUT_CYCLES+1 cycles after the REQ cycle.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use POLL_CYCLES=8, TIMEOUT_CYCLES=6 and a debouncer stub that answers STB_O with a one-cycle STB_I two cycles later.

1. **Reset and first poll:** release RST_I with i_enable=1 and stub DAT_I=8'h00. Required response:
   - STB_O pulses for one cycle, 8 cycles after release.
   - Successive pulses are 11 cycles apart.
   - o_alive toggles on each capture.
   - o_event stays 0.
2. **Press and release:** stub returns 8'h01, then 8'h05, then 8'h04. Required response:
   - o_pressed is 8'h01, then 8'h04, then 8'h00.
   - o_released is 8'h00, 8'h00, then 8'h01.
   - o_event pulses on each of the three captures.
   - o_status ends at 8'h04.
3. **Timeout:** stub silent for one poll. Required response:
   - o_timeout rises 7 cycles after the REQ cycle and stays high.
   - o_status is unchanged.
   - The next poll, answered with 8'h80, captures normally and o_timeout stays high.
4. **Collision:** stub replies exactly on the tcnt==0 cycle with 8'h10. Required response:
   - Capture occurs: o_status=8'h10, o_pressed=8'h10.
   - o_timeout remains 0.
5. **Enable gating:** drop i_enable for 20 cycles midway through IDLE, and separately during WAIT. Required response:
   - No STB_O pulses while i_enable is low.
   - The interval resumes from the held pcnt value.
   - An in-flight reply during WAIT is still captured.
6. **Async reset mid-WAIT:** assert RST_I between clock edges during WAIT, then deliver a late STB_I with 8'hFF. Required response:
   - All outputs are at reset values before the next edge.
   - The late STB_I is ignored: o_status=8'h00 and no event pulses.
